// File: rtl/clock_guard_if.sv
// Bundle between the guard sequencer and its environment (the requester and the clock bank's
// compare/reset ports). The master side is the sequencer.
interface clock_guard_if #(
  parameter int MAX_TERMS = 4
);
  // Handshake: start is a one-shot request that is honoured only while busy=0 and otherwise
  // dropped (never queued); done is a one-cycle completion pulse and pass is valid from done
  // until the next accepted start; there is no backpressure on either side.
  logic                     start;
  logic [3:0]               num_terms;
  logic [16*MAX_TERMS-1:0]  guard_terms;
  logic [7:0]               reset_mask;

  logic                     cmp_val;
  logic                     cmp_lng;
  logic                     cmp_op;
  logic [1:0]               cmp_addr;
  logic [3:0]               cmp_imm_lo;
  logic [7:0]               cmp_imm_hi;

  logic                     en_clk_reset;
  logic [7:0]               clk_reset;
  logic                     hold;
  logic                     busy;
  logic                     done;
  logic                     pass;

  modport master (
    input  start, num_terms, guard_terms, reset_mask, cmp_val,
    output cmp_lng, cmp_op, cmp_addr, cmp_imm_lo, cmp_imm_hi,
    output en_clk_reset, clk_reset, hold, busy, done, pass
  );

  modport slave (
    output start, num_terms, guard_terms, reset_mask, cmp_val,
    input  cmp_lng, cmp_op, cmp_addr, cmp_imm_lo, cmp_imm_hi,
    input  en_clk_reset, clk_reset, hold, busy, done, pass
  );
endinterface

// File: rtl/clock_guard_sequencer.sv
// Evaluates a latched guard one clock constraint per cycle against the clock bank's compare
// port, then fires a one-cycle clock-reset strobe when every term held.
module clock_guard_sequencer #(
  parameter int MAX_TERMS = 4
) (
  input  logic                clk,
  input  logic                reset,
  clock_guard_if.master       bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int         IDX_W   = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_TERMS);

  state_e                     state_q, state_d;
  logic [MAX_TERMS-1:0][15:0] terms_q, terms_d;
  logic [3:0]                 count_q, count_d;
  logic [7:0]                 mask_q, mask_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       pass_q, pass_d;

  logic [3:0]                 clamped_count;
  logic [15:0]                cur_term;
  logic                       last_term;

  always_comb begin
    clamped_count = (bus.num_terms > MAX_CNT) ? MAX_CNT : bus.num_terms;
    cur_term      = terms_q[idx_q];
    last_term     = ({{(4-IDX_W){1'b0}}, idx_q} == (count_q - 4'd1));
  end

  // Next-state and latched-operand logic. cmp_val is only meaningful during EVAL.
  always_comb begin
    state_d = state_q;
    terms_d = terms_q;
    count_d = count_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          terms_d = bus.guard_terms;
          count_d = clamped_count;
          mask_d  = bus.reset_mask;
          idx_d   = '0;
          pass_d  = 1'b0;
          state_d = (clamped_count != 4'd0) ? EVAL : COMMIT;
        end
      end
      EVAL: begin
        if (!bus.cmp_val) begin
          pass_d  = 1'b0;
          state_d = FINISH;
        end else if (last_term) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      COMMIT: begin
        pass_d  = 1'b1;
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the registered state so nothing leaks outside its own state.
  always_comb begin
    bus.cmp_lng      = 1'b0;
    bus.cmp_op       = 1'b0;
    bus.cmp_addr     = 2'd0;
    bus.cmp_imm_lo   = 4'd0;
    bus.cmp_imm_hi   = 8'd0;
    bus.en_clk_reset = 1'b0;
    bus.clk_reset    = 8'd0;
    bus.hold         = 1'b0;
    case (state_q)
      EVAL: begin
        {bus.cmp_lng, bus.cmp_op, bus.cmp_addr, bus.cmp_imm_lo, bus.cmp_imm_hi} = cur_term;
        bus.hold = 1'b1;
      end
      COMMIT: begin
        bus.en_clk_reset = 1'b1;
        bus.clk_reset    = mask_q;
        bus.hold         = 1'b1;
      end
      default: begin
        bus.hold = 1'b0;
      end
    endcase
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == FINISH);
    bus.pass  = pass_q;
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      terms_q <= '0;
      count_q <= 4'd0;
      mask_q  <= 8'd0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      terms_q <= terms_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_clock_guard_sequencer.sv
// Bench for clock_guard_sequencer: directed scenarios plus randomized guards, checked by a
// scoreboard fed from a term-list reference model.
module tb_clock_guard_sequencer;

  localparam int MAX_TERMS   = 4;
  localparam int TW          = 16 * MAX_TERMS;
  localparam int EXP_W       = 18;  // {pass, strobe, mask[7:0], latency[7:0]}
  localparam int MODE_PARITY = 0;
  localparam int MODE_ONES   = 1;
  localparam int MODE_BANK   = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  clock_guard_if #(.MAX_TERMS(MAX_TERMS)) bus();

  clock_guard_sequencer #(.MAX_TERMS(MAX_TERMS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- responder: compare port and a small clock bank ----------------
  // Bank clocks 1..4 sit at addr 0..3; long immediates are {imm_hi, imm_lo}, short ones imm_lo.
  int          resp_mode = MODE_ONES;
  logic [11:0] bank_clk [4];
  logic [11:0] bank_snap [4];
  logic        bank_load = 1'b0;
  logic [15:0] cmp_bundle;
  logic        resp_val;

  function automatic logic bank_cmp(input logic [15:0] t, input logic [11:0] clkv);
    logic [11:0] val;
    val = t[15] ? {t[7:0], t[11:8]} : {8'h00, t[11:8]};
    return t[14] ? (clkv == val) : (clkv < val);
  endfunction

  always_comb begin
    cmp_bundle = {bus.cmp_lng, bus.cmp_op, bus.cmp_addr, bus.cmp_imm_lo, bus.cmp_imm_hi};
    case (resp_mode)
      MODE_ONES: resp_val = 1'b1;
      MODE_BANK: resp_val = bank_cmp(cmp_bundle, bank_clk[bus.cmp_addr]);
      default:   resp_val = ^cmp_bundle;
    endcase
  end
  assign bus.cmp_val = resp_val;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)                                   bank_clk[i] <= 12'd0;
      else if (bank_load)                          bank_clk[i] <= bank_snap[i];
      else if (bus.en_clk_reset && bus.clk_reset[i]) bank_clk[i] <= 12'd0;
      else if (!bus.hold)                          bank_clk[i] <= bank_clk[i] + 12'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q [$];
  logic [15:0]      cmp_q [$];
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a term passes per the responder rule, evaluated on the frozen snapshot.
  function automatic logic ref_ok(input logic [15:0] t);
    case (resp_mode)
      MODE_ONES: return 1'b1;
      MODE_BANK: return bank_cmp(t, bank_snap[t[13:12]]);
      default:   return ^t;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic             busy_prev = 1'b0;
  logic             done_prev = 1'b0;
  logic             last_pass = 1'b0;
  int               cyc = 0;
  int               strobe_cnt = 0;
  logic [7:0]       strobe_mask = 8'd0;
  logic [EXP_W-1:0] mon_e;

  always @(negedge clk) begin
    if (reset) begin
      check("reset_outs", 32'({bus.busy, bus.hold, bus.done, bus.pass, bus.en_clk_reset,
                               bus.clk_reset, cmp_bundle}), 32'd0);
      busy_prev   = 1'b0;
      done_prev   = 1'b0;
      last_pass   = 1'b0;
      cyc         = 0;
      strobe_cnt  = 0;
      strobe_mask = 8'd0;
    end else begin
      if (bus.busy && !busy_prev) begin
        cyc         = 1;
        strobe_cnt  = 0;
        strobe_mask = 8'd0;
      end else begin
        cyc++;
      end
      if (done_prev) check("idle_after_done", 32'(bus.busy), 32'd0);
      if (!bus.busy) begin
        check("idle_outs", 32'({bus.hold, bus.done, bus.en_clk_reset, bus.clk_reset, cmp_bundle}),
              32'd0);
        check("pass_held", 32'(bus.pass), 32'(last_pass));
      end else begin
        if (!bus.done) check("hold_busy", 32'(bus.hold), 32'd1);
        if (bus.hold && !bus.en_clk_reset) begin
          if (cmp_q.size() == 0) check("cmp_extra", 32'd1, 32'd0);
          else                   check("cmp_term", 32'(cmp_bundle), 32'(cmp_q.pop_front()));
        end else begin
          check("cmp_zero", 32'(cmp_bundle), 32'd0);
        end
        if (bus.en_clk_reset) begin
          strobe_cnt++;
          strobe_mask = bus.clk_reset;
        end else begin
          check("mask_zero", 32'(bus.clk_reset), 32'd0);
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("done_extra", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("pass", 32'(bus.pass), 32'(mon_e[17]));
            check("strobe_count", 32'(strobe_cnt), 32'(mon_e[16]));
            check("strobe_mask", 32'(strobe_mask), 32'(mon_e[15:8]));
            check("latency", 32'(cyc), 32'(mon_e[7:0]));
            check("hold_in_done", 32'(bus.hold), 32'd0);
            last_pass = mon_e[17];
            if (resp_mode == MODE_BANK) check("bank_clk1_cleared", 32'(bank_clk[0]), 32'd0);
          end
        end
      end
      busy_prev = bus.busy;
      done_prev = bus.done;
    end
  end

  // ---------------- driver ----------------
  // Issues one guard; returns just after the edge that ends the done cycle.
  task automatic run_job(input logic [3:0] n, input logic [TW-1:0] terms, input logic [7:0] mask,
                         input int pulse_at, input bit hold_tail);
    int   cnt;
    int   lat;
    int   pulse;
    logic ok;
    logic [15:0] t;
    cnt = (int'(n) > MAX_TERMS) ? MAX_TERMS : int'(n);
    ok  = 1'b1;
    lat = cnt + 2;
    for (int i = 0; i < cnt; i++) begin
      t = terms[16*i +: 16];
      cmp_q.push_back(t);
      if (!ref_ok(t)) begin
        ok  = 1'b0;
        lat = i + 2;
        break;
      end
    end
    exp_q.push_back({ok, ok, (ok ? mask : 8'h00), 8'(lat)});
    pulse = (pulse_at < 0) ? int'($urandom_range(1, lat)) : pulse_at;

    bus.num_terms   = n;
    bus.guard_terms = terms;
    bus.reset_mask  = mask;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bank_load = 1'b0;
    for (int e = 1; e <= lat; e++) begin
      bus.start = (e == pulse) || (hold_tail && e == lat);
      @(posedge clk); #1;
    end
    bus.start = hold_tail;
  endtask

  task automatic run_abort_in_commit(input logic [3:0] n, input logic [TW-1:0] terms);
    for (int i = 0; i < int'(n); i++) cmp_q.push_back(terms[16*i +: 16]);
    bus.num_terms   = n;
    bus.guard_terms = terms;
    bus.reset_mask  = 8'hFF;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (int'(n)) @(posedge clk);
    @(negedge clk);
    check("abort_strobe_seen", 32'(bus.en_clk_reset), 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    cmp_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [TW-1:0] rt;
    logic [15:0]   t16;
    bit            ht;

    bus.start       = 1'b0;
    bus.num_terms   = 4'd0;
    bus.guard_terms = '0;
    bus.reset_mask  = 8'd0;
    for (int i = 0; i < 4; i++) bank_snap[i] = 12'd0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    resp_mode = MODE_ONES;
    run_job(4'd2, {32'h0, 16'h9F01, 16'h4300}, 8'h05, 0, 1'b0);
    resp_mode = MODE_PARITY;
    run_job(4'd3, {16'h0, 16'h0007, 16'h0003, 16'h0001}, 8'hFF, 0, 1'b0);
    resp_mode = MODE_ONES;
    run_job(4'd0, '0, 8'hA5, 0, 1'b0);
    run_job(4'd0, '0, 8'h00, 0, 1'b0);
    run_job(4'd15, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 8'h3C, 0, 1'b0);
    run_job(4'd4, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 8'h81, 2, 1'b0);

    // Failing guard with start held through FINISH, then the follow-on accept.
    resp_mode = MODE_PARITY;
    run_job(4'd2, {32'h0, 16'h0001, 16'h0003}, 8'h11, 0, 1'b1);
    run_job(4'd1, {48'h0, 16'h0100}, 8'h22, 0, 1'b0);

    resp_mode = MODE_ONES;
    run_abort_in_commit(4'd2, {32'h0, 16'hABCD, 16'h1357});
    run_job(4'd1, {48'h0, 16'h2468}, 8'h0F, 0, 1'b0);

    resp_mode    = MODE_BANK;
    bank_snap[0] = 12'd5;
    bank_load    = 1'b1;
    run_job(4'd2, {32'h0, 16'h8600, 16'hC500}, 8'h01, 0, 1'b0);
    bank_snap[0] = 12'd0;

    resp_mode = MODE_PARITY;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < MAX_TERMS; i++) begin
        t16 = 16'($urandom);
        if ($urandom_range(0, 3) != 0 && !(^t16)) t16[0] = ~t16[0];
        rt[16*i +: 16] = t16;
      end
      ht = ($urandom_range(0, 3) == 0);
      run_job(4'($urandom_range(0, 15)), rt, 8'($urandom),
              ($urandom_range(0, 1) == 1) ? -1 : 0, ht);
      if (!ht) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bus.start = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("cmp_q_drained", 32'(cmp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_guard_sequencer.md
# clock_guard_sequencer

Initiator for the clock-constraint compare port and the clock-reset command of the clock bank. Given a transition guard of up to MAX_TERMS clock constraints plus a reset mask, it issues one constraint per cycle to the bank's compare port and ANDs the returned results. Evaluation stops at the first failing term. If the whole guard passes, it fires a one-cycle clock-reset command. While it evaluates, it freezes the clock counters so that every term sees the same snapshot.

## Interface
Parameters:
- MAX_TERMS, 4, maximum number of constraint terms per guard (1..8).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- num_terms  in  4  number of valid terms; values above MAX_TERMS are clamped to MAX_TERMS.
- guard_terms  in  16*MAX_TERMS  term i is at [16i+15:16i], packed as {lng[15], op[14], addr[13:12], imm_lo[11:8], imm_hi[7:0]}.
- reset_mask  in  8  clocks to reset if the guard passes.
- cmp_val  in  1  combinational compare result returned by the clock bank.
- cmp_lng, cmp_op  out  1 each  compare-port select and operation (op=1 equals, op=0 less-than).
- cmp_addr  out  2  clock address.
- cmp_imm_lo  out  4  low compare immediate.
- cmp_imm_hi  out  8  high compare immediate.
- en_clk_reset  out  1  clock-reset strobe.
- clk_reset  out  8  clock-reset mask.
- hold  out  1  freeze request; the top level gates the clock-bank enable with ~hold.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- pass  out  1  guard result; valid from done and held until the next accepted start.

## Operation
- **Latch on accept.** In IDLE, start=1 latches guard_terms, the clamped num_terms and reset_mask. It clears idx and sets acc=1. Inputs other than cmp_val are ignored afterwards.
- **States:** IDLE, EVAL, COMMIT, FINISH.
- **IDLE → next state:** goes to EVAL if the clamped count is greater than 0, otherwise to COMMIT.
- **EVAL**
  - cmp_* drive latched term[idx] combinationally.
  - cmp_val is sampled at the closing edge.
  - If cmp_val=0: pass←0, go to FINISH, no COMMIT.
  - Else if idx=count-1: go to COMMIT.
  - Else: idx←idx+1.
- **COMMIT**
  - en_clk_reset=1 and clk_reset=latched mask for exactly one cycle.
  - pass←1, then go to FINISH.
  - A mask of 0 still produces the strobe, with clk_reset=0.
- **FINISH:** done=1, then return to IDLE.
- **hold:** 1 in EVAL and COMMIT, 0 in IDLE and FINISH.
- **Idle port values:** cmp_* are all 0 outside EVAL. en_clk_reset and clk_reset are 0 outside COMMIT.
- **Start while busy:** ignored, not queued.
- **Start in FINISH:** ignored. A new start is accepted on the cycle after done.
- **idx width:** clog2(MAX_TERMS), minimum 1 bit. It never wraps, because the count is clamped.
- **Reset mid-operation:** returns to IDLE at the reset edge with no commit. It clears hold, busy, done, pass and en_clk_reset/clk_reset. A COMMIT cut by reset produces no strobe in the following cycle.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, idx=0.
- **Full pass, N terms:** start is sampled at edge 0.
  - EVAL occupies cycles 1..N, one term per cycle.
  - COMMIT is cycle N+1.
  - done=1, pass=1 in cycle N+2.
- **Failure at term k** (1-based): done=1, pass=0 in cycle k+1; no strobe.
- **N=0:** COMMIT in cycle 1, done in cycle 2, pass=1.
- **Freeze:** hold rises in cycle 1 and falls in the done cycle. Counters therefore do not advance between terms or before the reset strobe.
- **Combinational path:** cmp_val is combinational from the cmp_* outputs. No extra pipeline stage is allowed.

## Test plan
- **N=2 pass:** reset, then start with num_terms=2, term0={0,1,0,4'd3,0}, term1={1,0,1,4'hF,8'h01}, reset_mask=8'h05, cmp_val forced 1 → cmp_imm_lo=3 in cycle 1, cmp_imm_hi=8'h01 in cycle 2, en_clk_reset=1 with clk_reset=8'h05 in cycle 3 only, done=pass=1 in cycle 4.
- **Early fail:** num_terms=3, cmp_val=0 in cycle 2 → done in cycle 3, pass=0, en_clk_reset never asserts, cmp_* return to 0 in cycle 3.
- **Empty and clamped counts:**
  - num_terms=0 → strobe in cycle 1, done=1 and pass=1 in cycle 2.
  - num_terms=15 with MAX_TERMS=4 → exactly 4 EVAL cycles.
- **Restart rules:** a start pulse during EVAL is ignored. A start held high through FINISH is accepted on the first IDLE cycle. pass holds at 0 after a failing guard until that next accept.
- **Reset mid-operation:** assert reset in the COMMIT cycle → next cycle has all outputs 0, no strobe, and a subsequent start runs normally.
- **Integration with the real clock bank:** counters are frozen while hold=1. Test with clock 1 = 12'd5 and terms {1,1,0,4'd5,0} then {1,0,0,4'd6,0} → pass=1, and clock 1 reads 0 after the cycle following the strobe.
